// File: rtl/pwm_sched_pkg.sv
// pwm_sched_pkg: shared types and constants for the PWM duty scheduler.
//   state_t            : scheduler FSM states
//   DUTY_W             : duty word width
//   PWM_PERIOD_CYCLES  : clk_50M cycles per PWM period
//   DUTY_MAX           : largest duty value the generator accepts
package pwm_sched_pkg;
   typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;
   localparam int DUTY_W = 4;
   localparam int PWM_PERIOD_CYCLES = 256;
   localparam int DUTY_MAX = 15;
endpackage

// File: rtl/pwm_duty_scheduler_if.sv
// pwm_duty_scheduler_if: requester/generator bus of the duty scheduler.
//   period_tick : start-of-period pulse from the PWM generator
//   req_valid   : per-requester pending request
//   req_duty    : packed requested duties, 4 bits per requester
//   req_ready   : one-hot accept pulse
//   duty_cycle  : duty driven to the PWM generator
//   owner       : index of the last granted requester
//   busy        : scheduler in RAMP or HOLD
interface pwm_duty_scheduler_if import pwm_sched_pkg::*; #(parameter int NUM_REQ = 4);
   logic                         period_tick;
   logic [NUM_REQ-1:0]           req_valid;
   logic [DUTY_W*NUM_REQ-1:0]    req_duty;
   logic [NUM_REQ-1:0]           req_ready;
   logic [DUTY_W-1:0]            duty_cycle;
   logic [$clog2(NUM_REQ)-1:0]   owner;
   logic                         busy;
   modport master (output period_tick, req_valid, req_duty, input req_ready, duty_cycle, owner, busy);
   modport slave  (input period_tick, req_valid, req_duty, output req_ready, duty_cycle, owner, busy);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotating-priority search.
//   req_valid  : pending requests
//   last_grant : index granted last; search starts one past it
//   enable     : gates the grant
//   grant      : one-hot grant (zero when disabled or nothing pending)
//   grant_idx  : index of the granted requester
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IW-1:0]      last_grant,
   input  logic               enable,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      grant_idx
);
   always_comb begin
      grant = '0;
      grant_idx = '0;
      // walk from farthest to nearest so the nearest valid requester wins
      for (int k = NUM_REQ; k >= 1; k--) begin
         int j;
         j = int'(last_grant) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (enable && req_valid[j]) begin
            grant = '0;
            grant[j] = 1'b1;
            grant_idx = IW'(j);
         end
      end
   end
endmodule

// File: rtl/pwm_duty_scheduler.sv
// pwm_duty_scheduler: round-robin owner of the shared PWM duty with period-aligned ramping.
//   clk_50M : system clock
//   reset   : asynchronous active-high reset
//   bus     : requester/generator bus (slave side)
module pwm_duty_scheduler import pwm_sched_pkg::*; #(
   parameter int NUM_REQ = 4,
   parameter int RAMP_STEP = 1,
   parameter int HOLD_PERIODS = 2
) (
   input  logic clk_50M,
   input  logic reset,
   pwm_duty_scheduler_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);
   state_t              state, state_n;
   logic [3:0]          hold_cnt, hold_n;
   logic [DUTY_W-1:0]   target, target_n, duty_n, req_d;
   logic [IW-1:0]       last_grant, last_n, owner_n, grant_idx;
   logic [NUM_REQ-1:0]  grant;
   logic                arb_en, up, reached;
   logic [4:0]          diff, step, sum;
   // arbitration only at a period boundary when the generator is free
   assign arb_en = bus.period_tick && (state == IDLE || (state == HOLD && hold_cnt == 4'd0));
   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req_valid  (bus.req_valid),
      .last_grant (last_grant),
      .enable     (arb_en),
      .grant      (grant),
      .grant_idx  (grant_idx)
   );
   assign req_d = bus.req_duty[DUTY_W*grant_idx +: DUTY_W];
   // 5-bit magnitude plus direction keeps the step from ever wrapping
   always_comb begin
      up = target > bus.duty_cycle;
      diff = up ? {1'b0, target} - {1'b0, bus.duty_cycle} : {1'b0, bus.duty_cycle} - {1'b0, target};
      step = diff < 5'(RAMP_STEP) ? diff : 5'(RAMP_STEP);
      sum = up ? {1'b0, bus.duty_cycle} + step
               : (step > {1'b0, bus.duty_cycle} ? 5'd0 : {1'b0, bus.duty_cycle} - step);
      reached = step == diff;
   end
   always_comb begin
      state_n = state;
      hold_n = hold_cnt;
      target_n = target;
      duty_n = bus.duty_cycle;
      owner_n = bus.owner;
      last_n = last_grant;
      if (arb_en) begin
         if (|grant) begin
            target_n = req_d;
            owner_n = grant_idx;
            last_n = grant_idx;
            state_n = req_d != bus.duty_cycle ? RAMP : HOLD;
            hold_n = 4'(HOLD_PERIODS);
         end else state_n = IDLE;
      end else if (bus.period_tick && state == RAMP) begin
         duty_n = sum > 5'(DUTY_MAX) ? 4'(DUTY_MAX) : sum[3:0];
         if (reached) begin
            state_n = HOLD;
            hold_n = 4'(HOLD_PERIODS);
         end
      end else if (bus.period_tick && state == HOLD && hold_cnt != 4'd0) hold_n = hold_cnt - 4'd1;
   end
   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         hold_cnt <= '0;
         target <= '0;
         last_grant <= IW'(NUM_REQ - 1);
         bus.duty_cycle <= '0;
         bus.owner <= '0;
         bus.busy <= 1'b0;
         bus.req_ready <= '0;
      end else begin
         state <= state_n;
         hold_cnt <= hold_n;
         target <= target_n;
         last_grant <= last_n;
         bus.duty_cycle <= duty_n;
         bus.owner <= owner_n;
         bus.busy <= state_n != IDLE;
         bus.req_ready <= grant;
      end
   end
endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// tb_pwm_duty_scheduler: directed bench with a grant scoreboard for the duty scheduler.
module tb_pwm_duty_scheduler;
   import pwm_sched_pkg::*;
   localparam int GAP = 16;
   logic clk_50M = 1'b0;
   logic reset = 1'b1;
   int tests = 0;
   int failed = 0;
   int q0[$];
   int q1[$];
   pwm_duty_scheduler_if #(.NUM_REQ(4)) b0 ();
   pwm_duty_scheduler_if #(.NUM_REQ(4)) b1 ();
   pwm_duty_scheduler #(.NUM_REQ(4), .RAMP_STEP(1), .HOLD_PERIODS(2)) u0 (
      .clk_50M (clk_50M), .reset (reset), .bus (b0.slave));
   pwm_duty_scheduler #(.NUM_REQ(4), .RAMP_STEP(4), .HOLD_PERIODS(2)) u1 (
      .clk_50M (clk_50M), .reset (reset), .bus (b1.slave));
   always #10 clk_50M = ~clk_50M;
   always @(negedge clk_50M) begin
      if (b0.req_ready != 4'd0) begin
         tests++;
         if (q0.size() == 0) begin
            failed++;
            $display("FAIL grant0_unexpected: ready=%b owner=%0d none expected", b0.req_ready, b0.owner);
         end else begin
            int e;
            e = q0.pop_front();
            if (b0.req_ready != 4'(1 << e) || int'(b0.owner) != e) begin
               failed++;
               $display("FAIL grant0: ready=%b owner=%0d expected index %0d", b0.req_ready, b0.owner, e);
            end
         end
      end
      if (b1.req_ready != 4'd0) begin
         tests++;
         if (q1.size() == 0) begin
            failed++;
            $display("FAIL grant1_unexpected: ready=%b owner=%0d none expected", b1.req_ready, b1.owner);
         end else begin
            int e;
            e = q1.pop_front();
            if (b1.req_ready != 4'(1 << e) || int'(b1.owner) != e) begin
               failed++;
               $display("FAIL grant1: ready=%b owner=%0d expected index %0d", b1.req_ready, b1.owner, e);
            end
         end
      end
   end
   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic tick(input int gap);
      repeat (gap - 1) @(posedge clk_50M);
      #1 b0.period_tick = 1'b1; b1.period_tick = 1'b1;
      @(posedge clk_50M);
      #1 b0.period_tick = 1'b0; b1.period_tick = 1'b0;
   endtask
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick(GAP);
   endtask
   task automatic reset_dut();
      #1 reset = 1'b1;
      repeat (2) @(posedge clk_50M);
      #1 reset = 1'b0;
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time expired");
      $fatal(1, "watchdog");
   end
   initial begin
      b0.period_tick = 1'b0; b0.req_valid = '0; b0.req_duty = '0;
      b1.period_tick = 1'b0; b1.req_valid = '0; b1.req_duty = '0;
      reset_dut();
      chk("reset_duty", int'(b0.duty_cycle), 0);
      chk("reset_busy", int'(b0.busy), 0);
      chk("reset_owner", int'(b0.owner), 0);
      chk("reset_ready", int'(b0.req_ready), 0);
      for (int i = 0; i < 3; i++) begin
         tick(PWM_PERIOD_CYCLES);
         chk("idle_duty", int'(b0.duty_cycle), 0);
         chk("idle_busy", int'(b0.busy), 0);
      end
      // single request, duty 5
      b0.req_duty[3:0] = 4'd5;
      b0.req_valid[0] = 1'b1;
      q0.push_back(0);
      tick(GAP);
      b0.req_valid[0] = 1'b0;
      chk("single_grant_busy", int'(b0.busy), 1);
      chk("single_grant_duty", int'(b0.duty_cycle), 0);
      for (int d = 1; d <= 5; d++) begin
         tick(GAP);
         chk("single_ramp", int'(b0.duty_cycle), d);
      end
      ticks(2);
      chk("single_hold_busy", int'(b0.busy), 1);
      tick(GAP);
      chk("single_idle_busy", int'(b0.busy), 0);
      chk("single_idle_duty", int'(b0.duty_cycle), 5);
      // four requesters, round robin from reset
      reset_dut();
      b0.req_duty = {4'd12, 4'd9, 4'd6, 4'd3};
      b0.req_valid = 4'hF;
      for (int i = 0; i < 4; i++) begin
         int n;
         n = 0;
         q0.push_back(i);
         do begin
            tick(GAP);
            n++;
         end while (b0.req_ready == 4'd0 && n < 20);
         chk("rr_grant_tick_gap", n, i == 0 ? 1 : 6);
         b0.req_valid[i] = 1'b0;
      end
      ticks(3);
      chk("rr_final_duty", int'(b0.duty_cycle), 12);
      // target equal to current duty goes straight to HOLD
      reset_dut();
      b0.req_duty = {4'd0, 4'd0, 4'd7, 4'd7};
      b0.req_valid = 4'b0011;
      q0.push_back(0);
      tick(GAP);
      b0.req_valid[0] = 1'b0;
      ticks(7);
      chk("same_pre_duty", int'(b0.duty_cycle), 7);
      ticks(2);
      q0.push_back(1);
      tick(GAP);
      b0.req_valid[1] = 1'b0;
      chk("same_owner", int'(b0.owner), 1);
      chk("same_duty", int'(b0.duty_cycle), 7);
      chk("same_busy0", int'(b0.busy), 1);
      tick(GAP);
      chk("same_busy1", int'(b0.busy), 1);
      tick(GAP);
      chk("same_busy2", int'(b0.busy), 1);
      tick(GAP);
      chk("same_busy3", int'(b0.busy), 0);
      chk("same_duty_end", int'(b0.duty_cycle), 7);
      // RAMP_STEP=4: 0->12, 12->4, 4->15 with a clipped final step
      b1.req_duty = {4'd0, 4'd15, 4'd4, 4'd12};
      b1.req_valid = 4'b0111;
      q1.push_back(0);
      tick(GAP);
      b1.req_valid[0] = 1'b0;
      for (int d = 4; d <= 12; d += 4) begin
         tick(GAP);
         chk("step4_up", int'(b1.duty_cycle), d);
      end
      ticks(2);
      q1.push_back(1);
      tick(GAP);
      b1.req_valid[1] = 1'b0;
      tick(GAP);
      chk("step4_down_a", int'(b1.duty_cycle), 8);
      tick(GAP);
      chk("step4_down_b", int'(b1.duty_cycle), 4);
      ticks(2);
      q1.push_back(2);
      tick(GAP);
      b1.req_valid[2] = 1'b0;
      tick(GAP);
      chk("step4_sat_a", int'(b1.duty_cycle), 8);
      tick(GAP);
      chk("step4_sat_b", int'(b1.duty_cycle), 12);
      tick(GAP);
      chk("step4_sat_c", int'(b1.duty_cycle), 15);
      tick(GAP);
      chk("step4_sat_hold", int'(b1.duty_cycle), 15);
      // asynchronous reset mid-ramp, pending request re-granted afterwards
      reset_dut();
      b0.req_duty = {4'd0, 4'd0, 4'd0, 4'd10};
      b0.req_valid = 4'b0001;
      q0.push_back(0);
      ticks(4);
      chk("rst_pre_duty", int'(b0.duty_cycle), 3);
      chk("rst_pre_busy", int'(b0.busy), 1);
      @(posedge clk_50M);
      #3 reset = 1'b1;
      #1;
      chk("rst_async_duty", int'(b0.duty_cycle), 0);
      chk("rst_async_busy", int'(b0.busy), 0);
      repeat (2) @(posedge clk_50M);
      #1 reset = 1'b0;
      q0.push_back(0);
      tick(GAP);
      b0.req_valid[0] = 1'b0;
      chk("rst_regrant_owner", int'(b0.owner), 0);
      chk("rst_regrant_busy", int'(b0.busy), 1);
      repeat (4) @(posedge clk_50M);
      chk("sb0_drained", q0.size(), 0);
      chk("sb1_drained", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
